// File: rtl/flap_game_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the flappy-column game.
// Screen geometry and column geometry are shared with the column generator
// and the VGA renderer, which decodes the game state encoding below.
package flap_game_ctrl_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int pipe_width    = 40;
  localparam int GAP_HEIGHT    = 60;
  localparam int PADDING       = 20;

  // Game state encoding seen by the renderer on the 'state' output.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } gameState_e;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Clamp a signed 12-bit screen y into 0..yMax; going off the top is legal.
  function automatic logic [10:0] clampY(input logic signed [11:0] y,
                                         input logic signed [11:0] yMax);
    logic [10:0] res;
    if (y < 12'sd0) begin
      res = '0;
    end else if (y > yMax) begin
      res = yMax[10:0];
    end else begin
      res = y[10:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/flap_game_ctrl_bcd_counter4.sv
// 4-digit BCD up-counter with synchronous clear and saturation at 9999.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   clr_i    synchronous clear (wins over increment)
//   inc_i    increment by one with decimal carry
//   count_o  four packed BCD digits, least significant digit in [3:0]
module bcd_counter4
  import flap_game_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;
  logic        carry;

  // Ripple a decimal carry through the digits. Blocking the increment at
  // 9999 means the top digit never needs to carry out.
  always_comb begin
    count_d = count_q;
    carry   = 1'b1;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != BCD_MAX)) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (count_q[d*4 +: 4] == 4'd9) begin
            count_d[d*4 +: 4] = 4'd0;
          end else begin
            count_d[d*4 +: 4] = count_q[d*4 +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/flap_game_ctrl.sv
// Game-level sequencer for the flappy-column game: state machine, bird
// vertical physics, collision against the two scrolling columns, and the
// BCD score / high score.
// Ports:
//   gameClk     game tick clock
//   reset       asynchronous active-low reset
//   btn         synchronized flap button level
//   Ax, Ay      column A right-side offset and gap centre
//   Bx, By      column B right-side offset and gap centre
//   passColumn  column-recycled pulse from the column generator
//   colReset    column generator reset (registered)
//   finished    column generator 'finished' input (registered)
//   birdY       bird top edge, screen y
//   state       IDLE=0, PLAY=1, DYING=2, OVER=3
//   score       4-digit BCD score
//   hiScore     4-digit BCD high score
module flap_game_ctrl
  import flap_game_ctrl_pkg::*;
#(
  parameter int BIRD_X      = 160,
  parameter int BIRD_SIZE   = 16,
  parameter int GRAVITY     = 1,
  parameter int FLAP_VEL    = 8,
  parameter int MAX_FALL    = 10,
  parameter int DEATH_TICKS = 64
) (
  input  logic        gameClk,
  input  logic        reset,
  input  logic        btn,
  input  logic [10:0] Ax,
  input  logic [10:0] Ay,
  input  logic [10:0] Bx,
  input  logic [10:0] By,
  input  logic        passColumn,
  output logic        colReset,
  output logic        finished,
  output logic [10:0] birdY,
  output logic [1:0]  state,
  output logic [15:0] score,
  output logic [15:0] hiScore
);

  localparam logic signed [11:0] GRAV_V    = 12'(GRAVITY);
  localparam logic signed [11:0] FLAP_V    = 12'(FLAP_VEL);
  localparam logic signed [11:0] MAXF_V    = 12'(MAX_FALL);
  localparam logic signed [11:0] BIRD_L_V  = 12'(BIRD_X);
  localparam logic signed [11:0] BIRD_R_V  = 12'(BIRD_X + BIRD_SIZE - 1);
  localparam logic signed [11:0] SIZE_V    = 12'(BIRD_SIZE);
  localparam logic signed [11:0] BOT_OFS_V = 12'(BIRD_SIZE - 1);
  localparam logic signed [11:0] YMAX_V    = 12'(SCREEN_HEIGHT - BIRD_SIZE);
  localparam logic signed [11:0] SCR_H_V   = 12'(SCREEN_HEIGHT);
  localparam logic signed [11:0] PIPE_V    = 12'(pipe_width);
  localparam logic signed [11:0] GAP_V     = 12'(GAP_HEIGHT);
  localparam logic [10:0]        Y_CENTER  = 11'(SCREEN_HEIGHT / 2);
  localparam int                 CNT_W     = $clog2(DEATH_TICKS);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEATH_TICKS - 1);

  gameState_e         state_q;
  logic [10:0]        birdY_q;
  logic signed [11:0] vel_q;
  logic               btn_q;
  logic               colReset_q;
  logic               finished_q;
  logic [15:0]        hiScore_q;
  logic [CNT_W-1:0]   deathCnt_q;

  logic               flap;
  logic signed [11:0] yTop;
  logic signed [11:0] yBot;
  logic signed [11:0] velInc;
  logic signed [11:0] fallVel;
  logic [10:0]        birdYStep;
  logic               onFloor;
  logic signed [11:0] aRight, aLeft, aGapTop, aGapBot;
  logic signed [11:0] bRight, bLeft, bGapTop, bGapBot;
  logic               aOverlap, aOutside, bOverlap, bOutside;
  logic               hitAny;
  logic               scoreClr;
  logic               scoreInc;

  // A flap is a rising edge against last tick's button level.
  assign flap = btn & ~btn_q;

  // Physics: position moves by the old velocity, velocity falls toward the cap.
  assign yTop      = $signed({1'b0, birdY_q});
  assign yBot      = yTop + BOT_OFS_V;
  assign birdYStep = clampY(yTop + vel_q, YMAX_V);
  assign velInc    = vel_q + GRAV_V;
  assign fallVel   = (velInc > MAXF_V) ? MAXF_V : velInc;
  assign onFloor   = (yTop + SIZE_V) >= SCR_H_V;

  // Column A: span is [Ax-2*pipe_width+1, Ax-pipe_width]; negative = off-screen.
  assign aRight   = $signed({1'b0, Ax}) - PIPE_V;
  assign aLeft    = aRight - PIPE_V + 12'sd1;
  assign aGapTop  = $signed({1'b0, Ay}) - GAP_V;
  assign aGapBot  = $signed({1'b0, Ay}) + GAP_V;
  assign aOverlap = (aLeft <= BIRD_R_V) && (aRight >= BIRD_L_V);
  assign aOutside = (yTop < aGapTop) || (yBot > aGapBot);

  // Column B: same comparators as column A.
  assign bRight   = $signed({1'b0, Bx}) - PIPE_V;
  assign bLeft    = bRight - PIPE_V + 12'sd1;
  assign bGapTop  = $signed({1'b0, By}) - GAP_V;
  assign bGapBot  = $signed({1'b0, By}) + GAP_V;
  assign bOverlap = (bLeft <= BIRD_R_V) && (bRight >= BIRD_L_V);
  assign bOutside = (yTop < bGapTop) || (yBot > bGapBot);

  assign hitAny = (aOverlap && aOutside) || (bOverlap && bOutside);

  // passColumn is gated by the PLAY state so an X before the column
  // generator's first tick cannot reach the score.
  assign scoreClr = (state_q == IDLE) && flap;
  assign scoreInc = (state_q == PLAY) && passColumn;

  bcd_counter4 u_score (
    .clk_i   (gameClk),
    .rst_ni  (reset),
    .clr_i   (scoreClr),
    .inc_i   (scoreInc),
    .count_o (score)
  );

  // Game state machine with registered physics and column-generator controls.
  always_ff @(posedge gameClk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      birdY_q    <= Y_CENTER;
      vel_q      <= '0;
      btn_q      <= 1'b0;
      colReset_q <= 1'b1;
      finished_q <= 1'b0;
      hiScore_q  <= '0;
      deathCnt_q <= '0;
    end else begin
      btn_q <= btn;
      case (state_q)
        IDLE: begin
          birdY_q <= Y_CENTER;
          vel_q   <= '0;
          if (flap) begin
            state_q    <= PLAY;
            vel_q      <= -FLAP_V;
            colReset_q <= 1'b0;
          end
        end
        PLAY: begin
          birdY_q <= birdYStep;
          vel_q   <= flap ? -FLAP_V : fallVel;
          if (hitAny || onFloor) begin
            state_q    <= DYING;
            finished_q <= 1'b1;
            deathCnt_q <= '0;
          end
        end
        DYING: begin
          birdY_q <= birdYStep;
          vel_q   <= fallVel;
          if (onFloor || (deathCnt_q == CNT_LAST)) begin
            state_q <= OVER;
            // Packed BCD orders the same as the raw 16-bit word.
            if (score > hiScore_q) begin
              hiScore_q <= score;
            end
          end else begin
            deathCnt_q <= deathCnt_q + CNT_W'(1);
          end
        end
        OVER: begin
          if (flap) begin
            state_q    <= IDLE;
            colReset_q <= 1'b1;
            finished_q <= 1'b0;
            birdY_q    <= Y_CENTER;
            vel_q      <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state    = state_q;
  assign birdY    = birdY_q;
  assign colReset = colReset_q;
  assign finished = finished_q;
  assign hiScore  = hiScore_q;

endmodule

// File: tb/tb_flap_game_ctrl.sv
// Testbench for flap_game_ctrl: a behavioural game model predicts every
// output each tick; predictions and hand-derived key values go into a queue
// that is drained and compared after each game clock edge.
module tb_flap_game_ctrl;

  localparam int TB_BIRD_X = 160;
  localparam int TB_SIZE   = 16;
  localparam int TB_SCR_H  = 480;
  localparam int TB_PIPE_W = 40;
  localparam int TB_GAP_H  = 60;
  localparam int TB_FLAP   = 8;
  localparam int TB_MAXF   = 10;
  localparam int TB_GRAV   = 1;
  localparam int TB_DEATH  = 64;

  logic        gameClk = 1'b0;
  logic        reset;
  logic        btn;
  logic        passColumn;
  logic [10:0] Ax, Ay, Bx, By;
  logic        colReset, finished;
  logic [10:0] birdY;
  logic [1:0]  state;
  logic [15:0] score, hiScore;

  flap_game_ctrl dut (
    .gameClk    (gameClk),
    .reset      (reset),
    .btn        (btn),
    .Ax         (Ax),
    .Ay         (Ay),
    .Bx         (Bx),
    .By         (By),
    .passColumn (passColumn),
    .colReset   (colReset),
    .finished   (finished),
    .birdY      (birdY),
    .state      (state),
    .score      (score),
    .hiScore    (hiScore)
  );

  // 10-unit game clock.
  always #5 gameClk = ~gameClk;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } expect_t;

  expect_t expQ[$];
  int numCompared   = 0;
  int numMismatched = 0;

  // Behavioural game model (integers, decimal score).
  int mState, mY, mV, mScore, mHi, mColReset, mFin, mBtnQ, mCnt;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] toBcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] sample(input int sel);
    case (sel)
      0:       return {14'b0, state};
      1:       return {5'b0, birdY};
      2:       return score;
      3:       return hiScore;
      4:       return {15'b0, colReset};
      default: return {15'b0, finished};
    endcase
  endfunction

  function automatic int clampI(input int y);
    if (y < 0) return 0;
    if (y > TB_SCR_H - TB_SIZE) return TB_SCR_H - TB_SIZE;
    return y;
  endfunction

  function automatic bit colHit(input int cx, input int cy);
    int  left, right;
    bit  overlap, outside;
    right   = cx - TB_PIPE_W;
    left    = cx - 2 * TB_PIPE_W + 1;
    overlap = (left <= TB_BIRD_X + TB_SIZE - 1) && (right >= TB_BIRD_X);
    outside = (mY < cy - TB_GAP_H) || (mY + TB_SIZE - 1 > cy + TB_GAP_H);
    return overlap && outside;
  endfunction

  task automatic pushExp(input string tag, input int sel, input logic [15:0] val);
    expect_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic modelReset();
    mState = 0; mY = TB_SCR_H / 2; mV = 0; mScore = 0; mHi = 0;
    mColReset = 1; mFin = 0; mBtnQ = 0; mCnt = 0;
  endtask

  task automatic modelStep(input int b, input int p, input int ax, input int ay,
                           input int bx, input int by);
    bit flapNow, hitNow, floorNow;
    flapNow  = (b != 0) && (mBtnQ == 0);
    mBtnQ    = b;
    hitNow   = colHit(ax, ay) || colHit(bx, by);
    floorNow = (mY + TB_SIZE >= TB_SCR_H);
    case (mState)
      0: begin
        mY = TB_SCR_H / 2;
        mV = 0;
        if (flapNow) begin
          mState = 1; mScore = 0; mV = -TB_FLAP; mColReset = 0;
        end
      end
      1: begin
        mY = clampI(mY + mV);
        mV = flapNow ? -TB_FLAP : ((mV + TB_GRAV > TB_MAXF) ? TB_MAXF : mV + TB_GRAV);
        if (p != 0) mScore = (mScore < 9999) ? mScore + 1 : 9999;
        if (hitNow || floorNow) begin
          mState = 2; mFin = 1; mCnt = 0;
        end
      end
      2: begin
        mY = clampI(mY + mV);
        mV = (mV + TB_GRAV > TB_MAXF) ? TB_MAXF : mV + TB_GRAV;
        if (floorNow || mCnt == TB_DEATH - 1) begin
          mState = 3;
          if (mScore > mHi) mHi = mScore;
        end else begin
          mCnt++;
        end
      end
      default: begin
        if (flapNow) begin
          mState = 0; mColReset = 1; mFin = 0; mY = TB_SCR_H / 2; mV = 0;
        end
      end
    endcase
  endtask

  // Drive one tick's inputs and queue the model's predicted outputs.
  task automatic applyStimulus(input int b, input int p, input int ax, input int ay,
                               input int bx, input int by);
    btn        = (b != 0);
    passColumn = (p != 0);
    Ax = 11'(ax); Ay = 11'(ay); Bx = 11'(bx); By = 11'(by);
    modelStep(b, p, ax, ay, bx, by);
    pushExp("model.state",    0, 16'(mState));
    pushExp("model.birdY",    1, 16'(mY));
    pushExp("model.score",    2, toBcd(mScore));
    pushExp("model.hiScore",  3, toBcd(mHi));
    pushExp("model.colReset", 4, 16'(mColReset));
    pushExp("model.finished", 5, 16'(mFin));
  endtask

  task automatic clockAndCompare();
    expect_t e;
    @(posedge gameClk);
    #1;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e.tag, sample(e.sel), e.val);
    end
  endtask

  task automatic step(input int b, input int p, input int ax, input int ay,
                      input int bx, input int by);
    applyStimulus(b, p, ax, ay, bx, by);
    clockAndCompare();
  endtask

  task automatic startGame(input string tag);
    step(0, 0, 0, 240, 0, 240);
    applyStimulus(1, 0, 0, 240, 0, 240);
    pushExp({tag, " start state"}, 0, 16'd1);
    pushExp({tag, " start colReset"}, 4, 16'd0);
    pushExp({tag, " start score"}, 2, 16'h0000);
    clockAndCompare();
  endtask

  task automatic restartFromOver(input string tag);
    step(0, 0, 0, 240, 0, 240);
    applyStimulus(1, 0, 0, 240, 0, 240);
    pushExp({tag, " idle state"}, 0, 16'd0);
    pushExp({tag, " idle colReset"}, 4, 16'd1);
    pushExp({tag, " idle birdY"}, 1, 16'd240);
    pushExp({tag, " idle finished"}, 5, 16'd0);
    clockAndCompare();
  endtask

  task automatic runToOver(input string tag, input logic [15:0] hiBefore,
                           input logic [15:0] hiAfter);
    for (int i = 0; i < TB_DEATH + 8 && mState != 3; i++) begin
      applyStimulus(1, 0, 0, 240, 0, 240);
      if (mState == 3) pushExp({tag, " hi at over"}, 3, hiAfter);
      else             pushExp({tag, " hi in dying"}, 3, hiBefore);
      clockAndCompare();
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " state"},    {14'b0, state},    16'd0);
    checkOutput({tag, " birdY"},    {5'b0, birdY},     16'd240);
    checkOutput({tag, " score"},    score,             16'h0000);
    checkOutput({tag, " hiScore"},  hiScore,           16'h0000);
    checkOutput({tag, " colReset"}, {15'b0, colReset}, 16'd1);
    checkOutput({tag, " finished"}, {15'b0, finished}, 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; btn = 1'b0; passColumn = 1'b0;
    Ax = '0; Ay = 11'd240; Bx = '0; By = 11'd240;
    #2 reset = 1'b0;
    #1 checkResetValues("reset held");
    #7 reset = 1'b1;
    #1 checkResetValues("reset released");
    modelReset();

    // passColumn while IDLE must not count.
    applyStimulus(0, 1, 0, 240, 0, 240);
    pushExp("idle pass score", 2, 16'h0000);
    clockAndCompare();

    // Game 1: a single flap then free fall to the floor.
    applyStimulus(1, 0, 0, 240, 0, 240);
    pushExp("g1 t1 state", 0, 16'd1);
    pushExp("g1 t1 colReset", 4, 16'd0);
    pushExp("g1 t1 birdY", 1, 16'd240);
    clockAndCompare();
    applyStimulus(1, 0, 0, 240, 0, 240);
    pushExp("g1 t2 birdY", 1, 16'd232);
    clockAndCompare();
    for (int t = 3; t <= 43; t++) begin
      applyStimulus(1, 0, 0, 240, 0, 240);
      if (t == 20) pushExp("g1 t20 birdY", 1, 16'd259);
      if (t == 21) pushExp("g1 t21 birdY", 1, 16'd269);
      if (t == 22) pushExp("g1 t22 birdY", 1, 16'd279);
      if (t == 41) begin
        pushExp("g1 floor birdY", 1, 16'd464);
        pushExp("g1 floor state", 0, 16'd1);
      end
      if (t == 42) begin
        pushExp("g1 dying state", 0, 16'd2);
        pushExp("g1 dying finished", 5, 16'd1);
      end
      if (t == 43) begin
        pushExp("g1 over state", 0, 16'd3);
        pushExp("g1 over hiScore", 3, 16'h0000);
      end
      clockAndCompare();
    end
    applyStimulus(0, 0, 0, 240, 0, 240);
    pushExp("g1 frozen birdY", 1, 16'd464);
    clockAndCompare();
    applyStimulus(1, 0, 0, 240, 0, 240);
    pushExp("g1 restart state", 0, 16'd0);
    pushExp("g1 restart colReset", 4, 16'd1);
    pushExp("g1 restart birdY", 1, 16'd240);
    clockAndCompare();

    // Game 2: pass and hit on the same tick with score 2.
    startGame("g2");
    step(1, 1, 0, 240, 0, 240);
    step(1, 0, 0, 240, 0, 240);
    applyStimulus(1, 1, 0, 240, 0, 240);
    pushExp("g2 score 2", 2, 16'h0002);
    clockAndCompare();
    applyStimulus(1, 1, 200, 400, 0, 240);
    pushExp("g2 coincide score", 2, 16'h0003);
    pushExp("g2 coincide state", 0, 16'd2);
    clockAndCompare();
    runToOver("g2", 16'h0000, 16'h0003);
    restartFromOver("g2");

    applyStimulus(0, 1, 0, 240, 0, 240);
    pushExp("idle2 pass score", 2, 16'h0003);
    clockAndCompare();

    // Game 3: score 5, no-overlap column, then column A hit above the gap.
    startGame("g3");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, (k % 2 == 0) ? 1 : 0, 0, 240, 0, 240);
      if (k == 4) pushExp("g3 three passes", 2, 16'h0003);
      if (k == 8) pushExp("g3 five passes", 2, 16'h0005);
      clockAndCompare();
    end
    applyStimulus(1, 0, 600, 400, 0, 240);
    pushExp("g3 no overlap state", 0, 16'd1);
    clockAndCompare();
    applyStimulus(1, 0, 200, 400, 0, 240);
    pushExp("g3 hit state", 0, 16'd2);
    pushExp("g3 hit finished", 5, 16'd1);
    clockAndCompare();
    step(0, 0, 0, 240, 0, 240);
    applyStimulus(1, 0, 0, 240, 0, 240);
    pushExp("g3 dying flap ignored", 0, 16'd2);
    clockAndCompare();
    runToOver("g3", 16'h0003, 16'h0005);
    restartFromOver("g3");

    // Game 4: score 3, column B hit below the gap; high score stays 5.
    startGame("g4");
    step(1, 1, 0, 240, 0, 240);
    step(1, 1, 0, 240, 0, 240);
    applyStimulus(1, 1, 0, 240, 0, 240);
    pushExp("g4 three passes", 2, 16'h0003);
    clockAndCompare();
    applyStimulus(1, 0, 0, 240, 200, 100);
    pushExp("g4 hitB state", 0, 16'd2);
    clockAndCompare();
    runToOver("g4", 16'h0005, 16'h0005);
    restartFromOver("g4");

    // Game 5: continuous passes with periodic flaps, decimal carry and saturation.
    startGame("g5");
    for (int i = 1; i <= 10005; i++) begin
      applyStimulus(((i % 16) < 8) ? 1 : 0, 1, 0, 240, 0, 240);
      if (i == 9)     pushExp("g5 score 9", 2, 16'h0009);
      if (i == 10)    pushExp("g5 score carry", 2, 16'h0010);
      if (i == 9999)  pushExp("g5 score 9999", 2, 16'h9999);
      if (i == 10005) begin
        pushExp("g5 score saturated", 2, 16'h9999);
        pushExp("g5 still playing", 0, 16'd1);
      end
      clockAndCompare();
    end

    // Asynchronous reset mid-PLAY, sampled before any further clock edge.
    #2 reset = 1'b0;
    #1 checkResetValues("async reset");
    #1 reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/flap_game_ctrl.md
Name: flap_game_ctrl

Overview:
- Game-level sequencer for the flappy-column game. Owns the game state machine, bird vertical physics, collision detection against the two scrolling columns, and the BCD score and high score.
- Drives the column generator's reset and `finished` inputs and consumes its column coordinates and `passColumn` pulse.
- Sits between the button synchronizer and the VGA renderer / 7-segment score display.

Parameters:
- BIRD_X, 160: fixed screen x of the bird's left edge.
- BIRD_SIZE, 16: bird box edge, in pixels.
- GRAVITY, 1: velocity increment per gameClk tick.
- FLAP_VEL, 8: upward speed loaded on a flap.
- MAX_FALL, 10: downward velocity cap.
- DEATH_TICKS, 64: maximum duration of the DYING state, in ticks.

Ports:
- gameClk  in  1  game tick clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- btn  in  1  synchronized flap button level.
- Ax, Ay, Bx, By  in  11 each  column right-side offset and gap center, as produced by the column generator.
- passColumn  in  1  column-recycled pulse.
- colReset  out  1  drives the column generator's reset.
- finished  out  1  drives the column generator's `finished` input.
- birdY  out  11  bird top edge, screen y.
- state  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3.
- score  out  16  4-digit BCD score.
- hiScore  out  16  4-digit BCD high score.

Behaviour:
- Reset (reset==0, asynchronous) forces all of the following:
  - state=IDLE, birdY=SCREEN_HEIGHT/2, velocity=0.
  - score=0, hiScore=0, colReset=1, finished=0.
  - Button-edge register cleared.
- Flap = btn rising edge, detected against a registered copy of btn. The detector is one register stage; a flap acts on the tick it is detected.
- Velocity is a signed 12-bit register. birdY arithmetic is done in signed 12 bits, then clamped to the range 0..SCREEN_HEIGHT-BIRD_SIZE.
- Column horizontal span is screen x in [A/Bx-2*pipe_width+1, A/Bx-pipe_width], computed in signed 12 bits. Negative values mean off-screen.
- Column gap is y in [A/By-GAP_HEIGHT, A/By+GAP_HEIGHT].
- Hit condition:
  - the bird box [BIRD_X, BIRD_X+BIRD_SIZE-1] overlaps a column span horizontally, and
  - the bird's top edge is above the gap top or its bottom edge is below the gap bottom.
- Floor condition: birdY+BIRD_SIZE >= SCREEN_HEIGHT.
- IDLE:
  - colReset=1, birdY held at center, velocity=0.
  - On a flap: next state is PLAY, score=0, velocity=-FLAP_VEL, colReset drops to 0 on the same edge.
- PLAY, updated each tick:
  - Velocity: -FLAP_VEL if flap, else min(velocity+GRAVITY, MAX_FALL).
  - birdY += old velocity (registered physics, one tick latency). Clamping at the top is not a death.
  - passColumn=1 increments score as BCD with decimal carry; score saturates at 0x9999.
  - Hit or floor on the registered birdY/columns moves to DYING on the next edge.
  - If passColumn and hit coincide, the score increments and the state enters DYING.
- DYING:
  - finished=1; flaps are ignored.
  - Gravity continues; birdY falls until the floor condition is met.
  - A tick counter forces OVER after DEATH_TICKS ticks even if the floor is never reached.
  - On entry to OVER: hiScore = score if score > hiScore (BCD compare equals binary compare of the 16-bit word).
- OVER:
  - finished=1, bird frozen.
  - On a flap: next state is IDLE, colReset=1, birdY recentred.
- passColumn is ignored in every state except PLAY, including while it is X before the column generator's first tick.
- colReset and finished are registered outputs; there are no combinational paths from inputs to outputs.
- hiScore is cleared only by reset.

Decomposition:
- Shared constants stay in the existing constants include (`constants.v`): SCREEN_WIDTH, SCREEN_HEIGHT, pipe_width, GAP_HEIGHT, PADDING.
- Add the state encodings IDLE/PLAY/DYING/OVER to that include; the renderer decodes `state`.
- One sub-module: bcd_counter4, a 4-digit BCD incrementer with clear and saturation, instantiated for score.
- Collision comparators stay inline, duplicated for columns A and B.

Test Plan:
- Reset low, then high -> state=0, birdY=240, score=0, hiScore=0, colReset=1, finished=0. Pulse reset low mid-PLAY -> the same values immediately, without waiting for a clock edge.
- IDLE, btn 0->1 -> tick 1: state=1, colReset=0, velocity=-8; tick 2: birdY=232. With no further flaps, velocity reaches +10 and holds. Floor reached (birdY>=464) -> DYING, then OVER.
- PLAY with 3 passColumn pulses -> score=0x0003. Preload score 0x0009 plus one pulse -> 0x0010. Preload 0x9999 plus a pulse -> stays 0x9999. passColumn in IDLE -> score unchanged.
- Ax=200, Ay=240, birdY=100 (above the gap top of 240-GAP_HEIGHT) -> DYING on the next tick, finished=1. The same case with Ax=600 (no horizontal overlap) -> remains in PLAY.
- Game one scores 5 and game two scores 3 -> hiScore=0x0005 after both; after game one hiScore updates on the DYING->OVER edge. Flap during DYING -> ignored. Flap in OVER -> IDLE with colReset=1.
- passColumn and a hit in the same tick with score=0x0002 -> score=0x0003, state=DYING; hiScore=0x0003 on entry to OVER.
